// File: rtl/config_frame_loader.sv
// config_frame_loader: assembles parity-protected bitstream words in a shadow
// register and commits the complete frame atomically to the mem/mem_inv
// select buses. A rejected or aborted frame never disturbs the committed bits.
module config_frame_loader #(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 4
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_W-1:0]     data_in,
  input  logic                  data_par,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [0:CHAIN_LEN-1]  mem,
  output logic [0:CHAIN_LEN-1]  mem_inv,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_perr;
  logic [0:CHAIN_LEN-1]  r_shadow, w_shadow_nxt;
  logic                  w_start, w_xfer, w_par_bad;

  // Abort wins over a coincident transfer, so the word is simply not taken.
  assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer    = (r_state == S_LOAD) && data_valid && !abort;
  assign w_par_bad = (data_par != (^data_in));

  // Each shadow bit listens only for the word that carries it; tail bits of
  // the last word beyond CHAIN_LEN have no destination and fall away.
  for (genvar gi = 0; gi < CHAIN_LEN; gi++) begin : g_bit
    localparam logic [CW-1:0] K = CW'(gi / WORD_W);
    assign w_shadow_nxt[gi] = (w_xfer && (r_cnt == K)) ? data_in[gi % WORD_W]
                                                       : r_shadow[gi];
  end

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake/status decode of the state register.
  always_comb begin
    w_next     = r_state;
    data_ready = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        if (abort)                             w_next = S_IDLE;
        else if (data_valid && (r_cnt == LAST)) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shadow assembly, word counter and sticky parity flag.
  always_ff @(posedge prog_clk) begin
    if (pReset || w_start) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_perr   <= 1'b0;
    end else if (w_xfer) begin
      r_shadow <= w_shadow_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_par_bad) r_perr <= 1'b1;
    end
  end

  // Atomic commit: mem/mem_inv move together, only on a clean frame.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      mem     <= '0;
      mem_inv <= '1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (w_start) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      if (!r_perr) begin
        mem     <= r_shadow;
        mem_inv <= ~r_shadow;
        done    <= 1'b1;
      end else begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader with a scoreboard of expected frame
// outcomes (mem, done, err) pushed when a frame is sent.
module tb_config_frame_loader;
  localparam int CL = 10;
  localparam int WW = 4;

  logic           prog_clk = 1'b0;
  logic           pReset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [WW-1:0]  data_in = '0;
  logic           data_par = 1'b0, data_valid = 1'b0;
  logic           data_ready, busy, done, err;
  logic [0:CL-1]  mem, mem_inv;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [0:CL-1] m;
    logic          d;
    logic          e;
  } exp_t;

  exp_t          sb[$];
  logic [0:CL-1] committed = '0;

  config_frame_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .data_in(data_in), .data_par(data_par), .data_valid(data_valid),
    .data_ready(data_ready), .mem(mem), .mem_inv(mem_inv),
    .busy(busy), .done(done), .err(err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [0:CL-1] obs, input logic [0:CL-1] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Stream bit i of the frame is bit i of {w2,w1,w0}; mem[0] is leftmost.
  function automatic logic [0:CL-1] model(input logic [WW-1:0] w0, w1, w2);
    logic [3*WW-1:0] s;
    logic [CL-1:0]   t;
    s = {w2, w1, w0};
    t = s[CL-1:0];
    return {<<{t}};
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic send(input logic [WW-1:0] w, input bit bad, input bit vld, output bit acc);
    data_in    = w;
    data_par   = (^w) ^ bad;
    data_valid = vld;
    acc        = vld && data_ready;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chkv({tag, "_mem"}, mem, e.m);
      chkv({tag, "_mem_inv"}, mem_inv, ~e.m);
      chk1({tag, "_done"}, done, e.d);
      chk1({tag, "_err"}, err, e.e);
      chk1({tag, "_busy"}, busy, 1'b0);
      committed = e.m;
    end
  endtask

  // Full frame, words on consecutive cycles; bad selects a corrupted word
  // (-1 for none); mid_start holds start high during the second word.
  task automatic load_frame(input string tag, input logic [WW-1:0] w0, w1, w2,
                            input int bad, input bit mid_start);
    exp_t e;
    bit   a;
    if (bad < 0) e = '{m: model(w0, w1, w2), d: 1'b1, e: 1'b0};
    else         e = '{m: committed, d: 1'b0, e: 1'b1};
    sb.push_back(e);
    do_start();
    chk1({tag, "_ready_load"}, data_ready, 1'b1);
    chk1({tag, "_busy_load"}, busy, 1'b1);
    chk1({tag, "_done_clr"}, done, 1'b0);
    send(w0, bad == 0, 1'b1, a);
    start = mid_start;
    send(w1, bad == 1, 1'b1, a);
    start = 1'b0;
    chk1({tag, "_busy_w2"}, busy, 1'b1);
    send(w2, bad == 2, 1'b1, a);
    chk1({tag, "_busy_commit"}, busy, 1'b1);
    chk1({tag, "_ready_commit"}, data_ready, 1'b0);
    chk1({tag, "_done_early"}, done, 1'b0);
    tick();
    check_result(tag);
  endtask

  initial begin
    bit a;
    int nacc;
    logic [WW-1:0] ws[6];
    bit            vs[6];

    // Reset state
    tick();
    tick();
    pReset = 1'b0;
    chkv("rst_mem", mem, '0);
    chkv("rst_mem_inv", mem_inv, '1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", data_ready, 1'b0);

    // Basic load
    load_frame("basic", 4'h5, 4'hA, 4'h3, -1, 1'b0);
    chkv("basic_lit", mem, 10'b1010010111);
    chkv("basic_lit_inv", mem_inv, 10'b0101101000);

    // Parity error on word 1: frame rejected, mem keeps the basic bits
    load_frame("parity", 4'hF, 4'h0, 4'hF, 1, 1'b0);
    chkv("parity_keep", mem, 10'b1010010111);

    // Clean different frame so the abort test can see mem held
    load_frame("alt", 4'hF, 4'h0, 4'hF, -1, 1'b0);
    chkv("alt_lit", mem, 10'b1111000011);

    // Abort coincident with the second word
    do_start();
    send(4'h5, 1'b0, 1'b1, a);
    abort = 1'b1;
    send(4'hA, 1'b0, 1'b1, a);
    abort = 1'b0;
    chk1("abort_ready", data_ready, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chkv("abort_mem", mem, 10'b1111000011);
    chk1("abort_done", done, 1'b0);
    chk1("abort_err", err, 1'b0);

    // data_valid in IDLE is ignored
    send(4'h5, 1'b0, 1'b1, a);
    chk1("idle_vld_ready", data_ready, 1'b0);
    chk1("idle_vld_busy", busy, 1'b0);
    chkv("idle_vld_mem", mem, 10'b1111000011);

    load_frame("post_abort", 4'h5, 4'hA, 4'h3, -1, 1'b0);
    chkv("post_abort_lit", mem, 10'b1010010111);

    // Handshake stalls: valid 1,0,0,1,0,1
    load_frame("alt2", 4'hF, 4'h0, 4'hF, -1, 1'b0);
    sb.push_back('{m: model(4'h5, 4'hA, 4'h3), d: 1'b1, e: 1'b0});
    ws = '{4'h5, 4'hA, 4'hA, 4'hA, 4'h3, 4'h3};
    vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    nacc = 0;
    do_start();
    for (int k = 0; k < 6; k++) begin
      send(ws[k], 1'b0, vs[k], a);
      if (a) nacc++;
    end
    n_cmp++;
    assert (nacc == 3) else begin
      n_err++;
      $error("FAIL stall_count: observed %0d expected 3", nacc);
    end
    chk1("stall_done_early", done, 1'b0);
    chk1("stall_busy_commit", busy, 1'b1);
    tick();
    check_result("stall");

    // Reset mid-LOAD with mem loaded
    do_start();
    send(4'h3, 1'b0, 1'b1, a);
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    chkv("midrst_mem", mem, '0);
    chkv("midrst_mem_inv", mem_inv, '1);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_err", err, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ready", data_ready, 1'b0);
    committed = '0;
    load_frame("after_rst", 4'h3, 4'hC, 4'h2, -1, 1'b0);

    // data_valid in DONE ignored
    send(4'h9, 1'b0, 1'b1, a);
    chk1("done_vld_done", done, 1'b1);
    chk1("done_vld_ready", data_ready, 1'b0);
    chkv("done_vld_mem", mem, committed);

    // start during LOAD ignored; counter still finishes at 3 words
    load_frame("mid_start", 4'h1, 4'h2, 4'h4, -1, 1'b1);

    // start in DONE: done drops next cycle, mem held
    do_start();
    chk1("restart_done", done, 1'b0);
    chk1("restart_busy", busy, 1'b1);
    chkv("restart_mem", mem, committed);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("final_ready", data_ready, 1'b0);
    chk1("sb_empty", sb.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
